// File: rtl/proc_ctrl_if.sv
// Control/datapath boundary of the TinyRV1 five-stage pipeline.
// master = control unit side, slave = datapath side.
interface proc_ctrl_if;
  logic [31:0] d2c_inst;
  logic        d2c_eq_X;
  logic        c2d_reg_en_F;
  logic [1:0]  c2d_pc_sel_F;
  logic        c2d_reg_en_D;
  logic [1:0]  c2d_op1_byp_sel_D;
  logic [1:0]  c2d_op2_byp_sel_D;
  logic        c2d_op1_sel_D;
  logic        c2d_op2_sel_D;
  logic [1:0]  c2d_imm_type_D;
  logic        c2d_alu_fn_X;
  logic        c2d_result_sel_X;
  logic        c2d_wb_sel_M;
  logic        c2d_dmemreq_val;
  logic        c2d_dmemreq_type;
  logic        c2d_rf_wen_W;
  logic [4:0]  c2d_rf_waddr_W;
  logic        c2d_imemreq_val;

  modport master (
    input  d2c_inst, d2c_eq_X,
    output c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D, c2d_op1_byp_sel_D,
           c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D, c2d_imm_type_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M, c2d_dmemreq_val,
           c2d_dmemreq_type, c2d_rf_wen_W, c2d_rf_waddr_W, c2d_imemreq_val
  );

  modport slave (
    output d2c_inst, d2c_eq_X,
    input  c2d_reg_en_F, c2d_pc_sel_F, c2d_reg_en_D, c2d_op1_byp_sel_D,
           c2d_op2_byp_sel_D, c2d_op1_sel_D, c2d_op2_sel_D, c2d_imm_type_D,
           c2d_alu_fn_X, c2d_result_sel_X, c2d_wb_sel_M, c2d_dmemreq_val,
           c2d_dmemreq_type, c2d_rf_wen_W, c2d_rf_waddr_W, c2d_imemreq_val
  );
endinterface

// File: rtl/proc_ctrl.sv
// TinyRV1 pipeline control: decode in D, per-stage valid/control tracking,
// bypass selection, load-use stall, jump/branch squash and dmem requests.
module proc_ctrl (
  input  logic      clk,
  input  logic      rst,
  proc_ctrl_if.master io_dp
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  logic [6:0] w_opc, w_f7;
  logic [2:0] w_f3;
  logic [4:0] w_rd, w_rs1, w_rs2;
  logic       w_add, w_addi, w_mul, w_lw, w_sw, w_jal, w_jr, w_bne;
  logic       w_use1, w_use2, w_wen_D;
  logic       w_stall_raw, w_stall, w_br, w_jump;
  logic       w_hit_X, w_hit_M, w_hit_W, w_rf_wen_W;

  logic       r_val_D, r_val_X, r_val_M, r_val_W;
  logic       r_wen_X, r_lw_X, r_sw_X, r_bne_X, r_mul_X;
  logic       r_wen_M, r_lw_M, r_sw_M, r_wen_W;
  logic [4:0] r_waddr_X, r_waddr_M, r_waddr_W;

  assign w_opc = io_dp.d2c_inst[6:0];
  assign w_rd  = io_dp.d2c_inst[11:7];
  assign w_f3  = io_dp.d2c_inst[14:12];
  assign w_rs1 = io_dp.d2c_inst[19:15];
  assign w_rs2 = io_dp.d2c_inst[24:20];
  assign w_f7  = io_dp.d2c_inst[31:25];

  // Anything not matched stays all-zero, so it flows down the pipe as a NOP.
  always_comb begin
    {w_add, w_addi, w_mul, w_lw, w_sw, w_jal, w_jr, w_bne} = 8'b0;
    case (w_opc)
      OP_R: begin
        w_add = (w_f3 == 3'b000) && (w_f7 == 7'b0000000);
        w_mul = (w_f3 == 3'b000) && (w_f7 == 7'b0000001);
      end
      OP_IMM:   w_addi = (w_f3 == 3'b000);
      OP_LOAD:  w_lw   = (w_f3 == 3'b010);
      OP_STORE: w_sw   = (w_f3 == 3'b010);
      OP_JAL:   w_jal  = 1'b1;
      OP_JALR:  w_jr   = (w_f3 == 3'b000);
      OP_BR:    w_bne  = (w_f3 == 3'b001);
      default:  ;
    endcase
  end

  assign w_use1  = w_add | w_addi | w_mul | w_lw | w_sw | w_jr | w_bne;
  assign w_use2  = w_add | w_mul | w_sw | w_bne;
  assign w_wen_D = w_add | w_addi | w_mul | w_lw | w_jal;

  assign w_hit_X = r_val_X & r_wen_X & (r_waddr_X != 5'd0);
  assign w_hit_M = r_val_M & r_wen_M & (r_waddr_M != 5'd0);
  assign w_hit_W = r_val_W & r_wen_W & (r_waddr_W != 5'd0);

  function automatic logic [1:0] f_byp(input logic used, input logic [4:0] src,
                                       input logic hx, input logic [4:0] ax,
                                       input logic hm, input logic [4:0] am,
                                       input logic hw, input logic [4:0] aw);
    logic [1:0] sel;
    sel = 2'd0;
    if (used && src != 5'd0) begin
      if (hx && ax == src)      sel = 2'd1;
      else if (hm && am == src) sel = 2'd2;
      else if (hw && aw == src) sel = 2'd3;
    end
    return sel;
  endfunction

  assign w_stall_raw = r_val_D & r_val_X & r_lw_X & (r_waddr_X != 5'd0) &
                       ((w_use1 & (w_rs1 == r_waddr_X)) | (w_use2 & (w_rs2 == r_waddr_X)));
  assign w_br    = r_val_X & r_bne_X & ~io_dp.d2c_eq_X;
  assign w_stall = w_stall_raw & ~w_br;
  assign w_jump  = r_val_D & (w_jal | w_jr) & ~w_stall & ~w_br;

  always_ff @(posedge clk) begin
    if (rst) begin
      {r_val_D, r_val_X, r_val_M, r_val_W} <= 4'b0;
      {r_wen_X, r_lw_X, r_sw_X, r_bne_X, r_mul_X} <= 5'b0;
      {r_wen_M, r_lw_M, r_sw_M, r_wen_W} <= 4'b0;
      r_waddr_X <= 5'd0;
      r_waddr_M <= 5'd0;
      r_waddr_W <= 5'd0;
    end else begin
      if (!w_stall) r_val_D <= ~(w_br | w_jump);
      r_val_X   <= r_val_D & ~w_stall & ~w_br;
      r_wen_X   <= w_wen_D;
      r_lw_X    <= w_lw;
      r_sw_X    <= w_sw;
      r_bne_X   <= w_bne;
      r_mul_X   <= w_mul;
      r_waddr_X <= w_rd;
      r_val_M   <= r_val_X;
      r_wen_M   <= r_wen_X;
      r_lw_M    <= r_lw_X;
      r_sw_M    <= r_sw_X;
      r_waddr_M <= r_waddr_X;
      r_val_W   <= r_val_M;
      r_wen_W   <= r_wen_M;
      r_waddr_W <= r_waddr_M;
    end
  end

  assign w_rf_wen_W = r_val_W & r_wen_W;

  // Everything is held at zero while rst is high, independent of stale stage state.
  always_comb begin
    io_dp.c2d_reg_en_F      = 1'b0;
    io_dp.c2d_pc_sel_F      = 2'd0;
    io_dp.c2d_reg_en_D      = 1'b0;
    io_dp.c2d_op1_byp_sel_D = 2'd0;
    io_dp.c2d_op2_byp_sel_D = 2'd0;
    io_dp.c2d_op1_sel_D     = 1'b0;
    io_dp.c2d_op2_sel_D     = 1'b0;
    io_dp.c2d_imm_type_D    = 2'd0;
    io_dp.c2d_alu_fn_X      = 1'b0;
    io_dp.c2d_result_sel_X  = 1'b0;
    io_dp.c2d_wb_sel_M      = 1'b0;
    io_dp.c2d_dmemreq_val   = 1'b0;
    io_dp.c2d_dmemreq_type  = 1'b0;
    io_dp.c2d_rf_wen_W      = 1'b0;
    io_dp.c2d_rf_waddr_W    = 5'd0;
    io_dp.c2d_imemreq_val   = 1'b0;
    if (!rst) begin
      io_dp.c2d_imemreq_val = 1'b1;
      io_dp.c2d_reg_en_F    = ~w_stall;
      io_dp.c2d_reg_en_D    = ~w_stall;
      if (w_br)        io_dp.c2d_pc_sel_F = 2'd3;
      else if (w_jump) io_dp.c2d_pc_sel_F = w_jal ? 2'd1 : 2'd2;
      io_dp.c2d_op1_byp_sel_D = f_byp(r_val_D & w_use1, w_rs1, w_hit_X, r_waddr_X,
                                      w_hit_M, r_waddr_M, w_hit_W, r_waddr_W);
      io_dp.c2d_op2_byp_sel_D = f_byp(r_val_D & w_use2, w_rs2, w_hit_X, r_waddr_X,
                                      w_hit_M, r_waddr_M, w_hit_W, r_waddr_W);
      io_dp.c2d_op1_sel_D = r_val_D & w_jal;
      io_dp.c2d_op2_sel_D = r_val_D & (w_addi | w_lw | w_sw | w_jal);
      if (r_val_D) begin
        if (w_sw)       io_dp.c2d_imm_type_D = 2'd1;
        else if (w_jal) io_dp.c2d_imm_type_D = 2'd2;
        else if (w_bne) io_dp.c2d_imm_type_D = 2'd3;
      end
      io_dp.c2d_alu_fn_X     = r_val_X & r_bne_X;
      io_dp.c2d_result_sel_X = r_val_X & r_mul_X;
      io_dp.c2d_wb_sel_M     = r_val_M & r_lw_M;
      io_dp.c2d_dmemreq_val  = r_val_M & (r_lw_M | r_sw_M);
      io_dp.c2d_dmemreq_type = r_val_M & r_sw_M;
      io_dp.c2d_rf_wen_W     = w_rf_wen_W;
      io_dp.c2d_rf_waddr_W   = w_rf_wen_W ? r_waddr_W : 5'd0;
    end
  end
endmodule

// File: doc/proc_ctrl.md
Name: proc_ctrl

Overview:
- Control unit for the five-stage (F/D/X/M/W) TinyRV1 processor datapath.
- Decodes the D-stage instruction and tracks per-stage valid bits and control bits.
- Drives every datapath select and enable, bypass selection, load-use stalls, jump and branch squashing, and data-memory requests.
- Sits beside the datapath inside the processor top; its c2d_* and d2c_* ports connect one-to-one.

Parameters:
none (ISA fixed to TinyRV1: ADD, ADDI, MUL, LW, SW, JAL, JR, BNE)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
d2c_inst  input  32  instruction in D (IR_FD output)
d2c_eq_X  input  1  ALU equality result of the X-stage instruction
c2d_reg_en_F  output  1  PC register enable
c2d_pc_sel_F  output  2  0 pc+4, 1 JAL target (D), 2 JR target (D bypassed rs1), 3 BNE target (X)
c2d_reg_en_D  output  1  IR_FD enable
c2d_op1_byp_sel_D  output  2  0 RF, 1 X, 2 M, 3 W
c2d_op2_byp_sel_D  output  2  same encoding for rs2
c2d_op1_sel_D  output  1  0 bypassed rs1, 1 pc_D
c2d_op2_sel_D  output  1  0 bypassed rs2, 1 immediate
c2d_imm_type_D  output  2  0 I, 1 S, 2 J-link (constant 4), 3 B
c2d_alu_fn_X  output  1  0 add, 1 equality compare
c2d_result_sel_X  output  1  0 ALU, 1 multiplier
c2d_wb_sel_M  output  1  0 result_X, 1 dmem response
c2d_dmemreq_val  output  1  data memory request valid (M)
c2d_dmemreq_type  output  1  0 read, 1 write
c2d_rf_wen_W  output  1  register-file write enable
c2d_rf_waddr_W  output  5  register-file write address
c2d_imemreq_val  output  1  instruction fetch valid

Behaviour:
- State: val_D, val_X, val_M, val_W, plus pipelined control per stage: op class, rf_wen, waddr, is_lw, is_sw, is_bne.
- Reset: all valid bits 0 and all outputs 0 while rst=1. The first cycle after reset has c2d_imemreq_val=1, reg_en_F=1, reg_en_D=1.
- Memory: imem and dmem are fixed-latency. Response data is valid in the same cycle as the request.
- Decode: D-stage fields come from d2c_inst per TinyRV1 encoding. An unrecognised opcode in a valid D is treated as a NOP (no write, no memory access).
- Per-instruction controls:
  - ADD: op1/op2 both bypassed.
  - ADDI: op2 = I immediate.
  - MUL: result_sel=1.
  - LW: op2 = I immediate, dmem read, wb_sel=1.
  - SW: op2 = S immediate, dmem write, no RF write.
  - JAL: op1 = pc, op2 = J-link, writes rd.
  - JR: no RF write.
  - BNE: alu_fn=1.
- Bypass:
  - For each source in D that the instruction reads, compare against X, then M, then W.
  - Priority is X > M > W.
  - A match requires: stage valid, stage rf_wen=1, waddr == source, and waddr != 0.
  - With no match, or source x0, select 0 (RF).
- Load-use stall:
  - Trigger: valid LW in X whose waddr matches a used D source (nonzero).
  - Effect: reg_en_F=0, reg_en_D=0, and a bubble goes into X (val_X_next=0).
  - The stall lasts exactly 1 cycle; the following cycle bypasses from M.
- JAL/JR in valid, unstalled D:
  - pc_sel=1 (JAL) or 2 (JR).
  - The instruction in F is squashed: val_D_next=0.
- BNE in valid X with d2c_eq_X=0 (taken):
  - pc_sel=3.
  - Both the F and D instructions are squashed: val_D_next=0, val_X_next=0.
- Priority of simultaneous events: taken BNE in X > load-use stall > jump in D > sequential.
  - A taken branch overrides a stall: reg_en_F=reg_en_D=1 and the bubble is loaded.
  - A JR whose operand is a stalled LW result does not redirect until the stall clears.
- dmemreq_val = val_M & (is_lw | is_sw). Squashed or bubble stages never assert rf_wen_W or dmemreq_val.
- c2d_imemreq_val = 1 in every non-reset cycle, including stall cycles (the fetch repeats).
- Reset asserted mid-operation clears all valid bits on the next edge. In-flight instructions never write.

Test Plan:
- addi x1,x0,5; add x2,x1,x1 back-to-back -> op1/op2_byp_sel_D=1 (X) for add; x2=10 at W; no stall.
- lw x3,0(x0) (mem[0]=7) then add x4,x3,x0 -> exactly one cycle with reg_en_F=reg_en_D=0; next cycle op1_byp_sel=2; x4=7.
- jal x1,+8 at pc 0x0 -> pc_sel=1 in JAL's D cycle; instruction at 0x4 never reaches W; x1=0x4; next fetch 0x8.
- bne x1,x0,-8 with x1=5 -> d2c_eq_X=0, pc_sel=3, two squashed slots, no rf_wen_W for either; bne with x1=0 -> no redirect.
- Taken BNE in X while D holds load-use consumer and jal follows -> pc_sel=3, reg_en_F=reg_en_D=1, neither squashed instruction writes.
- Assert rst for 1 cycle mid-stream with add in W -> rf_wen_W=0 next cycle; all outputs 0 during rst; fetch restarts with imemreq_val=1.
